// File: rtl/mips_run_pkg.sv
// Shared types for the MIPS run controller: controller state encoding and a
// small width helper used to size internal counters.
package mips_run_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips_halt_mon.sv
// Per-core halt monitor. Watches the valid PC samples of one core while the
// controller is running and latches a sticky halted flag once the same PC has
// been repeated STALL_LIMIT times in a row (counted over valid samples only).
module mips_halt_mon
  import mips_run_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic            i_pc_valid,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_halted,
  output logic            o_halted_next
);

  localparam int STALL_W = cnt_width(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);

  logic [PC_W-1:0]    r_prev_pc;
  logic               r_seen;
  logic [STALL_W-1:0] r_stall;
  logic               r_halted;

  logic [PC_W-1:0]    w_prev_pc;
  logic               w_seen;
  logic [STALL_W-1:0] w_stall;
  logic               w_halted;

  // Next-state of the monitor; a halted core is frozen until the next clear.
  always_comb begin
    w_prev_pc = r_prev_pc;
    w_seen    = r_seen;
    w_stall   = r_stall;
    w_halted  = r_halted;
    if (i_clr) begin
      w_prev_pc = '0;
      w_seen    = 1'b0;
      w_stall   = '0;
      w_halted  = 1'b0;
    end else if (i_en && !r_halted && i_pc_valid) begin
      if (!r_seen) begin
        // First sample of the run only establishes the reference PC.
        w_prev_pc = i_pc;
        w_seen    = 1'b1;
        w_stall   = '0;
      end else if (i_pc == r_prev_pc) begin
        if (r_stall != LIMIT) begin
          w_stall = r_stall + STALL_W'(1);
        end
        if (w_stall == LIMIT) begin
          w_halted = 1'b1;
        end
      end else begin
        w_stall   = '0;
        w_prev_pc = i_pc;
      end
    end
  end

  // Monitor state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_pc <= '0;
      r_seen    <= 1'b0;
      r_stall   <= '0;
      r_halted  <= 1'b0;
    end else begin
      r_prev_pc <= w_prev_pc;
      r_seen    <= w_seen;
      r_stall   <= w_stall;
      r_halted  <= w_halted;
    end
  end

  assign o_halted      = r_halted;
  assign o_halted_next = w_halted;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for one or more MIPS cores: holds the cores in reset for a
// fixed number of cycles after start, releases them, counts run cycles and
// ends the run when every core has halted or the cycle budget is used up.
// Cores stay out of reset after the run so their state can be inspected.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int NUM_CORES   = 1,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16,
  parameter int RESET_HOLD  = 4,
  parameter int MAX_CYCLES  = 600,
  parameter int STALL_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_CORES*PC_W-1:0] core_pc,
  input  logic [NUM_CORES-1:0]      core_pc_valid,
  output logic [NUM_CORES-1:0]      core_rst_n,
  output logic                      running,
  output logic                      done,
  output logic                      timeout,
  output logic [NUM_CORES-1:0]      halted_mask,
  output logic [CNT_W-1:0]          cycle_count
);

  localparam int HOLD_W = cnt_width(RESET_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_CYCLES - 1);

  run_state_e          r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [NUM_CORES-1:0] r_core_rst_n;
  logic                r_running;
  logic                r_done;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_cycle_count;

  logic                 w_hold_entry;
  logic                 w_mon_en;
  logic                 w_all_halted;
  logic                 w_budget_end;
  logic [NUM_CORES-1:0] w_halted;
  logic [NUM_CORES-1:0] w_halted_next;

  // A new run may only be launched from IDLE or DONE; start elsewhere is ignored.
  assign w_hold_entry = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_mon_en     = (r_state == ST_RUN);
  // Decided on the next-value of the halt flags so the exit edge also sets them.
  assign w_all_halted = &w_halted_next;
  assign w_budget_end = (r_cycle_count == LAST_CNT);

  genvar g;
  generate
    for (g = 0; g < NUM_CORES; g++) begin : g_mon
      mips_halt_mon #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
      ) u_mon (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (w_hold_entry),
        .i_en          (w_mon_en),
        .i_pc_valid    (core_pc_valid[g]),
        .i_pc          (core_pc[g*PC_W +: PC_W]),
        .o_halted      (w_halted[g]),
        .o_halted_next (w_halted_next[g])
      );
    end
  endgenerate

  // Run sequencing FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_hold_cnt    <= '0;
      r_core_rst_n  <= '0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hold_entry) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= ST_RUN;
            r_core_rst_n <= '1;
            r_running    <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          r_cycle_count <= r_cycle_count + CNT_W'(1);
          if (w_all_halted || w_budget_end) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= w_budget_end;
          end
        end
        ST_DONE: begin
          if (w_hold_entry) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_core_rst_n  <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_rst_n  = r_core_rst_n;
  assign running     = r_running;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign halted_mask = w_halted;
  assign cycle_count = r_cycle_count;

endmodule
